// File: rtl/countdown999.sv
// ---------------------------------------------------------------------------
// countdown999 -- three-digit BCD down-counter (999 .. 000) with 7-segment
// outputs, prescaled decrement tick and a four-state control FSM
// (IDLE / RUN / PAUSED / DONE).
//
// Optional feature macro: COUNTDOWN_BLANK_EN
//   defined   -> leading-zero blanking on the hundreds and tens digits
//   undefined -> every digit always shows its value, leading zeros included
// ---------------------------------------------------------------------------
module countdown999 #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [11:0] q,
    output logic [6:0]  uni,
    output logic [6:0]  dez,
    output logic [6:0]  cen,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_q;
    logic [25:0] r_tick_cnt;

    logic        w_tick;
    logic        w_q_zero;
    logic        w_q_one;
    logic        w_do_dec;
    logic [11:0] w_q_load;
    logic [11:0] w_q_dec;

    // Clamp a BCD digit to the legal 0..9 range.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Standard 0..9 segment patterns, bit 0 = a ... bit 6 = g, 1 = lit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Count-value decode shared by FSM and datapath.
    always_comb begin
        w_q_zero = (r_q == 12'h000);
        w_q_one  = (r_q == 12'h001);
        w_tick   = (r_state == S_RUN) && (r_tick_cnt == TICK_LAST);
        w_do_dec = (r_state == S_RUN) && !load && !pause && w_tick && !w_q_zero;
        w_q_load = {clamp_digit(load_val[11:8]),
                    clamp_digit(load_val[7:4]),
                    clamp_digit(load_val[3:0])};
    end

    // BCD decrement with borrow rippling units -> tens -> hundreds.
    always_comb begin
        logic [3:0] w_u;
        logic [3:0] w_t;
        logic [3:0] w_h;
        w_u = r_q[3:0];
        w_t = r_q[7:4];
        w_h = r_q[11:8];
        if (w_u != 4'd0) begin
            w_u = w_u - 4'd1;
        end else begin
            w_u = 4'd9;
            if (w_t != 4'd0) begin
                w_t = w_t - 4'd1;
            end else begin
                w_t = 4'd9;
                w_h = w_h - 4'd1;
            end
        end
        w_q_dec = {w_h, w_t, w_u};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; priority load > pause > start > tick.
    always_comb begin
        w_state_next = r_state;
        if (load) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!pause && start) begin
                        w_state_next = w_q_zero ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_next = S_PAUSED;
                    end else if (w_tick && (w_q_one || w_q_zero)) begin
                        w_state_next = S_DONE;
                    end
                end
                S_PAUSED: begin
                    if (!pause && start) begin
                        w_state_next = S_RUN;
                    end
                end
                S_DONE: begin
                    w_state_next = S_DONE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        running = (r_state == S_RUN);
        done    = (r_state == S_DONE);
    end

    // Count register: clamped load, else decrement on an unblocked tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_q_load;
        end else if (w_do_dec) begin
            r_q <= w_q_dec;
        end
    end

    // Prescaler: counts only while staying in RUN, so every entry to RUN
    // (and every load or pause) restarts a full TICK_DIV period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (load || (r_state != S_RUN) || (w_state_next != S_RUN)) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 26'd1;
        end
    end

    // Segment decode straight from the count, no output register.
    always_comb begin
        q   = r_q;
        uni = seg7(r_q[3:0]);
        dez = seg7(r_q[7:4]);
        cen = seg7(r_q[11:8]);
`ifdef COUNTDOWN_BLANK_EN
        if (r_q[11:8] == 4'd0) begin
            cen = '0;
            if (r_q[7:4] == 4'd0) begin
                dez = '0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_countdown999.sv
// ---------------------------------------------------------------------------
// tb_countdown999 -- directed self-checking bench for countdown999 with
// TICK_DIV = 4. Inputs change 1 ns after a rising edge; outputs are sampled
// at the same point, i.e. after the edge has taken effect.
// ---------------------------------------------------------------------------
module tb_countdown999;

    logic        clk;
    logic        rst;
    logic        load;
    logic [11:0] load_val;
    logic        start;
    logic        pause;
    logic [11:0] q;
    logic [6:0]  uni;
    logic [6:0]  dez;
    logic [6:0]  cen;
    logic        running;
    logic        done;

    int unsigned n_checks;
    int unsigned n_err;

    localparam logic [6:0] SEG0 = 7'b0111111;
    localparam logic [6:0] SEG1 = 7'b0000110;
    localparam logic [6:0] SEG2 = 7'b1011011;
    localparam logic [6:0] SEG3 = 7'b1001111;
    localparam logic [6:0] SEG9 = 7'b1101111;

`ifdef COUNTDOWN_BLANK_EN
    localparam logic [6:0] LEAD0 = 7'b0000000;
`else
    localparam logic [6:0] LEAD0 = SEG0;
`endif

    countdown999 #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .q        (q),
        .uni      (uni),
        .dez      (dez),
        .cen      (cen),
        .running  (running),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        load     = 1'b0;
        load_val = 12'h000;
        start    = 1'b0;
        pause    = 1'b0;
        cyc(2);

        // Reset state
        chk("rst_q",       32'(q),       32'h000);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_uni",     32'(uni),     32'(SEG0));
        chk("rst_dez",     32'(dez),     32'(LEAD0));
        chk("rst_cen",     32'(cen),     32'(LEAD0));
        rst = 1'b0;

        // 123 -> 122 -> 121
        load = 1'b1; load_val = 12'h123; cyc(1); load = 1'b0;
        chk("t1_load_q",   32'(q),       32'h123);
        chk("t1_idle",     32'(running), 32'd0);
        chk("t1_uni3",     32'(uni),     32'(SEG3));
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t1_running",  32'(running), 32'd1);
        cyc(3);
        chk("t1_q_hold3",  32'(q),       32'h123);
        cyc(1);
        chk("t1_q_122",    32'(q),       32'h122);
        chk("t1_uni2",     32'(uni),     32'(SEG2));
        cyc(4);
        chk("t1_q_121",    32'(q),       32'h121);
        chk("t1_uni1",     32'(uni),     32'(SEG1));

        // 100 -> 099 -> 098, load while running returns to IDLE
        load = 1'b1; load_val = 12'h100; cyc(1); load = 1'b0;
        chk("t2_load_idle", 32'(running), 32'd0);
        chk("t2_load_q",    32'(q),       32'h100);
        chk("t2_cen1",      32'(cen),     32'(SEG1));
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        chk("t2_q_099",    32'(q),       32'h099);
        chk("t2_cen",      32'(cen),     32'(LEAD0));
        chk("t2_dez9",     32'(dez),     32'(SEG9));
        chk("t2_uni9",     32'(uni),     32'(SEG9));
        cyc(4);
        chk("t2_q_098",    32'(q),       32'h098);

        // 002 -> 001 -> 000 + DONE, start then ignored
        load = 1'b1; load_val = 12'h002; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        chk("t3_q_001",    32'(q),       32'h001);
        chk("t3_done0",    32'(done),    32'd0);
        cyc(4);
        chk("t3_q_000",    32'(q),       32'h000);
        chk("t3_done1",    32'(done),    32'd1);
        chk("t3_run0",     32'(running), 32'd0);
        chk("t3_uni0",     32'(uni),     32'(SEG0));
        start = 1'b1; cyc(6); start = 1'b0;
        chk("t3_q_stay",   32'(q),       32'h000);
        chk("t3_done_hold",32'(done),    32'd1);

        // Pause freezes q; resume restarts a full period
        load = 1'b1; load_val = 12'h050; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        chk("t4_q_049",    32'(q),       32'h049);
        pause = 1'b1; cyc(5);
        chk("t4_paused_run", 32'(running), 32'd0);
        chk("t4_q_frz5",   32'(q),       32'h049);
        cyc(5);
        chk("t4_q_frz10",  32'(q),       32'h049);
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        chk("t4_resume",   32'(running), 32'd1);
        cyc(3);
        chk("t4_q_hold3",  32'(q),       32'h049);
        cyc(1);
        chk("t4_q_048",    32'(q),       32'h048);

        // Clamped load, then reset mid-run
        load = 1'b1; load_val = 12'hFAF; cyc(1); load = 1'b0;
        chk("t5_clamp999", 32'(q),       32'h999);
        load = 1'b1; load_val = 12'hA5F; cyc(1); load = 1'b0;
        chk("t5_clamp959", 32'(q),       32'h959);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        chk("t5_q_958",    32'(q),       32'h958);
        cyc(2);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("t5_rst_q",    32'(q),       32'h000);
        chk("t5_rst_run",  32'(running), 32'd0);
        chk("t5_rst_done", 32'(done),    32'd0);
        load = 1'b1; load_val = 12'h010; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        chk("t5_post_hold", 32'(q),      32'h010);
        cyc(1);
        chk("t5_post_009", 32'(q),       32'h009);

        // Start from 000 goes straight to DONE; load beats start
        load = 1'b1; load_val = 12'h000; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t6_zero_done", 32'(done),   32'd1);
        chk("t6_zero_q",    32'(q),      32'h000);
        chk("t6_zero_run",  32'(running),32'd0);
        load = 1'b1; start = 1'b1; load_val = 12'h055; cyc(1);
        load = 1'b0; start = 1'b0;
        chk("t6_ls_run",   32'(running), 32'd0);
        chk("t6_ls_done",  32'(done),    32'd0);
        chk("t6_ls_q",     32'(q),       32'h055);
        cyc(5);
        chk("t6_idle_hold", 32'(q),      32'h055);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown999.md
# countdown999

Three-digit BCD down-counter, 999 to 000, that drives the same three active-high 7-segment digit buses as the up-counting display path. It sits beside the 000–999 counter as its opposite-direction counterpart: a front panel loads a start value, starts and pauses it, and reads a done indication when the count reaches 000. Decrements are paced by an internal prescaler; all state is in a single clock domain.

## Interface
- TICK_DIV, default 50_000_000: clock cycles per decrement; legal range 1 to 2^26-1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  when high, captures load_val into the count and moves to IDLE.
- load_val  in  12  BCD start value; {hundreds[11:8], tens[7:4], units[3:0]}.
- start  in  1  begins or resumes counting (level-sampled every cycle).
- pause  in  1  halts counting while in RUN.
- q  out  12  current BCD count, same packing as load_val.
- uni, dez, cen  out  7 each  segment buses for units, tens and hundreds; bit 0 = a … bit 6 = g; 1 = segment lit.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- Reset: q=000, tick counter=0, state IDLE, running=0, done=0, segment buses show 0 (7'b0111111 in this bit order).
- Load: each load_val digit above 9 is clamped to 9 before capture; e.g. 0xA5F loads as 959.
- States: IDLE, RUN, PAUSED, DONE.
  - IDLE:
    - load → IDLE.
    - start with q≠000 → RUN.
    - start with q=000 → DONE.
  - RUN:
    - load → IDLE.
    - pause → PAUSED.
    - tick with q=001 → q=000, then DONE.
    - tick otherwise → q decrements.
  - PAUSED:
    - load → IDLE.
    - start with pause low → RUN.
  - DONE:
    - load → IDLE. q holds 000.
    - start is ignored.
- Priority within a cycle: rst > load > pause > start > tick.
- Decrement: BCD with borrow.
  - Units 0 → 9 and borrow from tens.
  - Tens 0 → 9 and borrow from hundreds.
  - q never wraps below 000; DONE is entered instead.
- Prescaler: a 26-bit counter runs only in RUN and counts 0…TICK_DIV-1. A tick occurs on the cycle it equals TICK_DIV-1; it then returns to 0. It clears to 0 on every entry to RUN and on load, so every run segment starts with a full period.
- Segment decode: combinational from q, using the standard 0–9 patterns. Digit codes above 9 cannot occur.

## Timing
- load, start and pause take effect at the clock edge where they are sampled; state, q and the flags update at that edge.
- Segment buses follow q in the same cycle, with no extra register.
- First decrement occurs TICK_DIV cycles after the edge that entered RUN; later decrements follow every TICK_DIV cycles.
- PAUSED freezes q and the prescaler value is discarded. Resuming restarts the full TICK_DIV period.
- done rises on the same edge that q becomes 000.
- rst asserted mid-run restores the reset values on the next edge; no tick is lost or duplicated after rst releases.
- TICK_DIV=1 decrements every cycle in RUN.

## Configuration
- COUNTDOWN_BLANK_EN defined: leading-zero blanking.
  - cen is 7'b0000000 when the hundreds digit is 0.
  - dez is 7'b0000000 when both hundreds and tens are 0.
  - uni is never blanked.
  - q is unaffected.
- COUNTDOWN_BLANK_EN undefined: all three digits always show their value, including leading zeros.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then load_val=0x123 and start for one cycle → running=1; q steps 123→122→121 every 4 cycles; uni shows 3, then 2, then 1.
- Load 0x100 and run → q goes 100→099→098; with COUNTDOWN_BLANK_EN, cen=0 and dez shows 9 at q=099.
- Load 0x002 and run → q=001 after 4 cycles and q=000 with done=1 after 8 cycles; start afterwards is ignored and q stays 000.
- Run from 0x050, hold pause for 10 cycles, then start → q is frozen during the pause; the next decrement occurs exactly 4 cycles after start.
- Load 0xFAF → q=999. Assert rst mid-run → q=000, IDLE, done=0 on the next edge.
- Load 0x000 and start → DONE on the next edge with no decrement. Load and start in the same cycle → load wins and the state is IDLE.
